// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer: next-state selects and condition indices.
package microseq_pkg;

   // Next-address select field of the microword
   localparam logic [2:0] NS_DECODE = 3'd0;
   localparam logic [2:0] NS_INC    = 3'd1;
   localparam logic [2:0] NS_JUMP   = 3'd2;
   localparam logic [2:0] NS_CJUMP  = 3'd3;
   localparam logic [2:0] NS_WAIT   = 3'd4;
   localparam logic [2:0] NS_CALL   = 3'd5;
   localparam logic [2:0] NS_RET    = 3'd6;
   localparam logic [2:0] NS_LOOP   = 3'd7;

   // Conventional positions in the condition vector
   localparam int unsigned COND_MOC = 0;
   localparam int unsigned COND_ARM = 1;

endpackage

// File: rtl/microsequencer_if.sv
// Sequencing bus between the microword/decoder side (master) and the microsequencer (slave).
interface microsequencer_if #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned NUM_COND    = 4,
   parameter int unsigned STACK_DEPTH = 4,
   parameter int unsigned CNT_W       = 8
);
   localparam int unsigned COND_SEL_W = (NUM_COND > 1) ? $clog2(NUM_COND) : 1;
   localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1);

   logic [2:0]            ns_sel;
   logic [COND_SEL_W-1:0] cond_sel;
   logic                  cond_inv;
   logic [ADDR_W-1:0]     target;
   logic [ADDR_W-1:0]     decode_addr;
   logic [NUM_COND-1:0]   cond_in;
   logic                  cnt_load;
   logic [CNT_W-1:0]      cnt_val;
   logic                  err_clr;
   logic [ADDR_W-1:0]     uaddr;
   logic [CNT_W-1:0]      loop_cnt;
   logic [DEPTH_W-1:0]    stk_depth;
   logic                  ovf;
   logic                  unf;

   modport master (
      output ns_sel, cond_sel, cond_inv, target, decode_addr, cond_in,
             cnt_load, cnt_val, err_clr,
      input  uaddr, loop_cnt, stk_depth, ovf, unf
   );

   modport slave (
      input  ns_sel, cond_sel, cond_inv, target, decode_addr, cond_in,
             cnt_load, cnt_val, err_clr,
      output uaddr, loop_cnt, stk_depth, ovf, unf
   );

endinterface

// File: rtl/microseq_stack.sv
// LIFO return-address stack for microsubroutine call/return.
// Push on full and pop on empty are ignored; the caller flags those cases.
module microseq_stack #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4,
   localparam int unsigned DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [ADDR_W-1:0]  din,
   output logic [ADDR_W-1:0]  dout,
   output logic               full,
   output logic               empty,
   output logic [DEPTH_W-1:0] depth
);
   localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [ADDR_W-1:0]  mem [STACK_DEPTH];
   logic [DEPTH_W-1:0] depth_q, depth_d;
   logic [IDX_W-1:0]   wr_idx, top_idx;
   logic               do_push, do_pop;

   assign full    = (depth_q == DEPTH_W'(STACK_DEPTH));
   assign empty   = (depth_q == '0);
   assign do_push = push & ~pop & ~full;
   assign do_pop  = pop & ~push & ~empty;
   assign wr_idx  = IDX_W'(depth_q);
   assign top_idx = IDX_W'(depth_q - DEPTH_W'(1));
   assign dout    = mem[top_idx];
   assign depth   = depth_q;

   // Occupancy update
   always_comb begin
      depth_d = depth_q;
      if (do_push) begin
         depth_d = depth_q + DEPTH_W'(1);
      end else if (do_pop) begin
         depth_d = depth_q - DEPTH_W'(1);
      end
   end

   // Occupancy register, cleared by reset
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Entry storage; contents after reset are don't-care
   always_ff @(posedge CLK) begin
      if (do_push) begin
         mem[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/microsequencer.sv
// Next-address engine for the microprogrammed control unit: condition mux with inversion,
// wait/hold, call/return stack, loop counter and sticky stack error flags.
// Optional macro MICROSEQ_LOOP_EN enables the loop counter and the LOOP select;
// without it LOOP behaves as INC and loop_cnt reads 0.
module microsequencer
   import microseq_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 8,
   parameter int unsigned       NUM_COND    = 4,
   parameter int unsigned       STACK_DEPTH = 4,
   parameter int unsigned       CNT_W       = 8,
   parameter logic [ADDR_W-1:0] RESET_ADDR  = '0
) (
   input logic              CLK,
   input logic              reset,
   microsequencer_if.slave  bus
);
   localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH + 1);

   logic [ADDR_W-1:0]  uaddr_q, uaddr_d, inc;
   logic               cond_raw, cond;
   logic               push, pop;
   logic [ADDR_W-1:0]  stk_dout;
   logic               stk_full, stk_empty;
   logic [DEPTH_W-1:0] stk_depth;
   logic               ovf_q, ovf_d, unf_q, unf_d;
   logic               ovf_set, unf_set;
`ifdef MICROSEQ_LOOP_EN
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               loop_dec;
`endif

   assign inc = uaddr_q + ADDR_W'(1);

   // Condition select; out-of-range indices read as 0 before inversion
   always_comb begin
      cond_raw = 1'b0;
      if (32'(bus.cond_sel) < NUM_COND) begin
         cond_raw = bus.cond_in[bus.cond_sel];
      end
      cond = cond_raw ^ bus.cond_inv;
   end

   // Next-address mux and stack/flag event decode
   always_comb begin
      uaddr_d = uaddr_q;
      push    = 1'b0;
      pop     = 1'b0;
      ovf_set = 1'b0;
      unf_set = 1'b0;
`ifdef MICROSEQ_LOOP_EN
      loop_dec = 1'b0;
`endif
      case (bus.ns_sel)
         NS_DECODE: uaddr_d = bus.decode_addr;
         NS_INC:    uaddr_d = inc;
         NS_JUMP:   uaddr_d = bus.target;
         NS_CJUMP:  uaddr_d = cond ? bus.target : inc;
         NS_WAIT:   uaddr_d = cond ? inc : uaddr_q;
         NS_CALL: begin
            // A full stack still takes the jump; the lost return address is flagged
            uaddr_d = bus.target;
            if (stk_full) begin
               ovf_set = 1'b1;
            end else begin
               push = 1'b1;
            end
         end
         NS_RET: begin
            if (stk_empty) begin
               uaddr_d = RESET_ADDR;
               unf_set = 1'b1;
            end else begin
               uaddr_d = stk_dout;
               pop     = 1'b1;
            end
         end
         NS_LOOP: begin
`ifdef MICROSEQ_LOOP_EN
            if (cnt_q != '0) begin
               uaddr_d  = bus.target;
               loop_dec = 1'b1;
            end else begin
               uaddr_d = inc;
            end
`else
            uaddr_d = inc;
`endif
         end
         default: uaddr_d = inc;
      endcase
   end

   // Sticky flags: a set event in the same cycle as err_clr wins
   always_comb begin
      ovf_d = (ovf_q & ~bus.err_clr) | ovf_set;
      unf_d = (unf_q & ~bus.err_clr) | unf_set;
   end

   // Address register and flags
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         uaddr_q <= RESET_ADDR;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         uaddr_q <= uaddr_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

`ifdef MICROSEQ_LOOP_EN
   // Loop counter next state: a load overrides the decrement; zero never decrements
   always_comb begin
      cnt_d = cnt_q;
      if (bus.cnt_load) begin
         cnt_d = bus.cnt_val;
      end else if (loop_dec) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // Loop counter register
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign bus.loop_cnt = cnt_q;
`else
   logic unused_loop;
   assign unused_loop  = ^{bus.cnt_load, bus.cnt_val};
   assign bus.loop_cnt = '0;
`endif

   microseq_stack #(
      .ADDR_W      (ADDR_W),
      .STACK_DEPTH (STACK_DEPTH)
   ) u_stack (
      .CLK   (CLK),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .din   (inc),
      .dout  (stk_dout),
      .full  (stk_full),
      .empty (stk_empty),
      .depth (stk_depth)
   );

   assign bus.uaddr     = uaddr_q;
   assign bus.stk_depth = stk_depth;
   assign bus.ovf       = ovf_q;
   assign bus.unf       = unf_q;

endmodule

// File: tb/tb_microsequencer.sv
// Directed bench for the microsequencer: stimulus pushes hand-computed expectations into a
// scoreboard queue, a monitor pops and compares after each clock edge or async reset event.
module tb_microsequencer;
   import microseq_pkg::*;

`ifdef MICROSEQ_LOOP_EN
   localparam int LE = 1;
`else
   localparam int LE = 0;
`endif

   typedef struct {
      string nm;
      int    ua;
      int    cnt;
      int    dep;
      int    ov;
      int    un;
   } exp_t;

   logic CLK;
   logic reset;
   exp_t sb[$];
   event async_ev;
   int   n_pass;
   int   n_total;

   logic [1:0] s_cs;
   logic       s_ci;
   logic [3:0] s_cin;
   logic [7:0] s_dec;
   logic       s_load;
   logic [7:0] s_val;
   logic       s_clr;

   microsequencer_if #(
      .ADDR_W      (8),
      .NUM_COND    (4),
      .STACK_DEPTH (4),
      .CNT_W       (8)
   ) bus ();

   microsequencer #(
      .ADDR_W      (8),
      .NUM_COND    (4),
      .STACK_DEPTH (4),
      .CNT_W       (8),
      .RESET_ADDR  (8'd0)
   ) dut (
      .CLK   (CLK),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Monitor: one scoreboard entry per clock edge (or async reset event)
   initial begin
      exp_t e;
      bit   ok;
      n_pass  = 0;
      n_total = 0;
      forever begin
         @(posedge CLK or async_ev);
         #1;
         if (sb.size() > 0) begin
            e  = sb.pop_front();
            ok = (bus.uaddr === 8'(e.ua)) && (bus.loop_cnt === 8'(e.cnt)) &&
                 (bus.stk_depth === 3'(e.dep)) && (bus.ovf === 1'(e.ov)) &&
                 (bus.unf === 1'(e.un));
            n_total++;
            if (ok) begin
               n_pass++;
            end else begin
               $display("FAIL %s: got uaddr=%0d cnt=%0d depth=%0d ovf=%b unf=%b, want uaddr=%0d cnt=%0d depth=%0d ovf=%0d unf=%0d",
                        e.nm, bus.uaddr, bus.loop_cnt, bus.stk_depth, bus.ovf, bus.unf,
                        e.ua, e.cnt, e.dep, e.ov, e.un);
            end
         end
      end
   end

   function automatic exp_t mk(input string nm, input int ua, cnt, dep, ov, un);
      exp_t e;
      e.nm  = nm;
      e.ua  = ua;
      e.cnt = cnt;
      e.dep = dep;
      e.ov  = ov;
      e.un  = un;
      return e;
   endfunction

   // Drive one microword at the falling edge; expectation is for after the next rising edge
   task automatic step(input string nm, input logic [2:0] ns, input logic [7:0] tgt,
                       input int ua, cnt, dep, ov, un);
      @(negedge CLK);
      bus.ns_sel      = ns;
      bus.target      = tgt;
      bus.cond_sel    = s_cs;
      bus.cond_inv    = s_ci;
      bus.cond_in     = s_cin;
      bus.decode_addr = s_dec;
      bus.cnt_load    = s_load;
      bus.cnt_val     = s_val;
      bus.err_clr     = s_clr;
      s_load          = 1'b0;
      s_clr           = 1'b0;
      sb.push_back(mk(nm, ua, cnt, dep, ov, un));
   endtask

   initial begin
      reset  = 1'b0;
      s_cs   = 2'(COND_MOC);
      s_ci   = 1'b0;
      s_cin  = 4'b0000;
      s_dec  = 8'd0;
      s_load = 1'b0;
      s_val  = 8'd0;
      s_clr  = 1'b0;
      bus.ns_sel      = NS_INC;
      bus.target      = 8'd0;
      bus.cond_sel    = 2'd0;
      bus.cond_inv    = 1'b0;
      bus.cond_in     = 4'd0;
      bus.decode_addr = 8'd0;
      bus.cnt_load    = 1'b0;
      bus.cnt_val     = 8'd0;
      bus.err_clr     = 1'b0;

      #12;
      sb.push_back(mk("reset_state", 0, 0, 0, 0, 0));
      -> async_ev;
      @(negedge CLK);
      reset      = 1'b1;
      bus.ns_sel = NS_JUMP;
      bus.target = 8'd255;

      // Address wrap
      step("jump_255", NS_JUMP, 8'd255, 255, 0, 0, 0, 0);
      step("inc_wrap", NS_INC,  8'd0,     0, 0, 0, 0, 0);

      // WAIT on MOC, then inverted
      step("jump_10",   NS_JUMP, 8'd10, 10, 0, 0, 0, 0);
      step("wait_h1",   NS_WAIT, 8'd0,  10, 0, 0, 0, 0);
      step("wait_h2",   NS_WAIT, 8'd0,  10, 0, 0, 0, 0);
      step("wait_h3",   NS_WAIT, 8'd0,  10, 0, 0, 0, 0);
      s_cin = 4'b0001;
      step("wait_go",   NS_WAIT, 8'd0,  11, 0, 0, 0, 0);
      step("jump_10b",  NS_JUMP, 8'd10, 10, 0, 0, 0, 0);
      s_ci  = 1'b1;
      s_cin = 4'b0000;
      step("winv_go",   NS_WAIT, 8'd0,  11, 0, 0, 0, 0);
      s_cin = 4'b0001;
      step("winv_hold", NS_WAIT, 8'd0,  11, 0, 0, 0, 0);
      s_cin = 4'b0000;
      step("winv_go2",  NS_WAIT, 8'd0,  12, 0, 0, 0, 0);
      s_ci  = 1'b0;

      // Call/return, overflow, LIFO order, underflow
      step("jump_5",  NS_JUMP, 8'd5,  5,  0, 0, 0, 0);
      step("call_40", NS_CALL, 8'd40, 40, 0, 1, 0, 0);
      step("ret_6",   NS_RET,  8'd0,  6,  0, 0, 0, 0);
      step("call_50", NS_CALL, 8'd50, 50, 0, 1, 0, 0);
      step("call_60", NS_CALL, 8'd60, 60, 0, 2, 0, 0);
      step("call_70", NS_CALL, 8'd70, 70, 0, 3, 0, 0);
      step("call_80", NS_CALL, 8'd80, 80, 0, 4, 0, 0);
      step("call_ovf", NS_CALL, 8'd90, 90, 0, 4, 1, 0);
      step("ret_71",  NS_RET,  8'd0,  71, 0, 3, 1, 0);
      step("ret_61",  NS_RET,  8'd0,  61, 0, 2, 1, 0);
      step("ret_51",  NS_RET,  8'd0,  51, 0, 1, 1, 0);
      step("ret_7",   NS_RET,  8'd0,  7,  0, 0, 1, 0);
      step("ret_unf", NS_RET,  8'd0,  0,  0, 0, 1, 1);
      s_clr = 1'b1;
      step("err_clr", NS_INC,  8'd0,  1,  0, 0, 0, 0);

      // Overflow in the same cycle as err_clr keeps ovf set
      step("call_100", NS_CALL, 8'd100, 100, 0, 1, 0, 0);
      step("call_101", NS_CALL, 8'd101, 101, 0, 2, 0, 0);
      step("call_102", NS_CALL, 8'd102, 102, 0, 3, 0, 0);
      step("call_103", NS_CALL, 8'd103, 103, 0, 4, 0, 0);
      s_clr = 1'b1;
      step("ovf_vs_clr", NS_CALL, 8'd104, 104, 0, 4, 1, 0);
      s_clr = 1'b1;
      step("clr_ovf",  NS_INC,  8'd0,   105, 0, 4, 0, 0);
      step("ret_103",  NS_RET,  8'd0,   103, 0, 3, 0, 0);

      // Loop counter
      s_load = 1'b1;
      s_val  = 8'd3;
      step("load_3",  NS_JUMP, 8'd22, 22, LE ? 3 : 0, 3, 0, 0);
      step("loop_a",  NS_LOOP, 8'd20, LE ? 20 : 23, LE ? 2 : 0, 3, 0, 0);
      step("jump_22a", NS_JUMP, 8'd22, 22, LE ? 2 : 0, 3, 0, 0);
      step("loop_b",  NS_LOOP, 8'd20, LE ? 20 : 23, LE ? 1 : 0, 3, 0, 0);
      step("jump_22b", NS_JUMP, 8'd22, 22, LE ? 1 : 0, 3, 0, 0);
      step("loop_c",  NS_LOOP, 8'd20, LE ? 20 : 23, 0, 3, 0, 0);
      step("jump_22c", NS_JUMP, 8'd22, 22, 0, 3, 0, 0);
      step("loop_exit", NS_LOOP, 8'd20, 23, 0, 3, 0, 0);
      s_load = 1'b1;
      s_val  = 8'd7;
      step("load_vs_loop0", NS_LOOP, 8'd20, 24, LE ? 7 : 0, 3, 0, 0);
      step("loop_7",  NS_LOOP, 8'd30, LE ? 30 : 25, LE ? 6 : 0, 3, 0, 0);
      s_load = 1'b1;
      s_val  = 8'd2;
      step("load_vs_loop6", NS_LOOP, 8'd40, LE ? 40 : 26, LE ? 2 : 0, 3, 0, 0);

      // DECODE and conditional jumps
      s_dec = 8'd38;
      step("decode_38", NS_DECODE, 8'd0, 38, LE ? 2 : 0, 3, 0, 0);
      s_cs  = 2'(COND_ARM);
      s_cin = 4'b0010;
      step("cjump_take", NS_CJUMP, 8'd60, 60, LE ? 2 : 0, 3, 0, 0);
      s_cin = 4'b0000;
      step("cjump_fall", NS_CJUMP, 8'd60, 61, LE ? 2 : 0, 3, 0, 0);
      s_ci  = 1'b1;
      step("cjump_inv",  NS_CJUMP, 8'd70, 70, LE ? 2 : 0, 3, 0, 0);
      s_cs  = 2'(COND_MOC);
      s_cin = 4'b0001;
      step("cjump_invf", NS_CJUMP, 8'd80, 71, LE ? 2 : 0, 3, 0, 0);
      s_ci  = 1'b0;
      s_cin = 4'b0000;

      // Async reset in the middle of a loop
      s_load = 1'b1;
      s_val  = 8'd5;
      step("load_5",  NS_INC,  8'd0,  72, LE ? 5 : 0, 3, 0, 0);
      step("loop_r",  NS_LOOP, 8'd10, LE ? 10 : 73, LE ? 4 : 0, 3, 0, 0);
      @(posedge CLK);
      #3;
      reset = 1'b0;
      sb.push_back(mk("async_reset", 0, 0, 0, 0, 0));
      -> async_ev;
      @(negedge CLK);
      reset      = 1'b1;
      bus.ns_sel = NS_INC;
      step("post_reset", NS_INC, 8'd0, 2, 0, 0, 0, 0);

      repeat (2) @(posedge CLK);
      #2;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/microsequencer.md
Name: microsequencer

Overview:
- Parametrised next-address engine for the microprogrammed control unit.
- Replaces the fixed incrementer register and 4-way next-state mux.
- Adds N-way condition selection with inversion, a wait/hold mode, a microsubroutine call/return stack and a loop counter.
- Drives the microstore address. Consumes the sequencing fields of the registered microword plus the decoder (encoder) address.

Parameters:
- ADDR_W, 8: microaddress width.
- NUM_COND, 4: number of condition inputs (bit 0 MOC, bit 1 Cond by convention).
- STACK_DEPTH, 4: return-stack entries (≥1).
- CNT_W, 8: loop counter width.
- RESET_ADDR, 0: microaddress after reset and after stack underflow.

Ports:
- CLK, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: asynchronous, active-low reset (asserted when 0).
- ns_sel, input, 3: next-state select from the microword.
- cond_sel, input, clog2(NUM_COND): condition index.
- cond_inv, input, 1: invert the selected condition.
- target, input, ADDR_W: jump/call/loop target from the microword CR field.
- decode_addr, input, ADDR_W: entry address from the instruction decoder.
- cond_in, input, NUM_COND: condition vector.
- cnt_load, input, 1: load the loop counter this cycle.
- cnt_val, input, CNT_W: loop counter load value.
- err_clr, input, 1: clear the sticky error flags.
- uaddr, output, ADDR_W: current microaddress (registered), fed to the microstore.
- loop_cnt, output, CNT_W: loop counter value.
- stk_depth, output, clog2(STACK_DEPTH+1): stack occupancy.
- ovf, output, 1: sticky stack overflow flag.
- unf, output, 1: sticky stack underflow flag.

Behaviour:
- Reset (reset=0, asynchronous): uaddr=RESET_ADDR, loop_cnt=0, stk_depth=0, ovf=0, unf=0, stack contents don't-care.
- cond = (cond_sel<NUM_COND ? cond_in[cond_sel] : 0) ^ cond_inv. Combinational, sampled at the edge.
- inc = uaddr+1, wrapping modulo 2^ADDR_W (max address goes to 0).
- Next uaddr by ns_sel, one-cycle latency (value present at edge k appears on uaddr after edge k):
  - 0 DECODE: decode_addr.
  - 1 INC: inc.
  - 2 JUMP: target.
  - 3 CJUMP: cond ? target : inc.
  - 4 WAIT: cond ? inc : uaddr. Hold until cond, used for MOC.
  - 5 CALL: push inc, go to target. If stack full: no push, still jump, set ovf.
  - 6 RET: pop top to uaddr. If stack empty: uaddr=RESET_ADDR, set unf, depth stays 0.
  - 7 LOOP: loop_cnt!=0 ? (loop_cnt-1, target) : inc.
- Loop counter:
  - cnt_load has priority over the LOOP decrement in the same cycle.
  - The branch decision always uses the pre-edge count; the count becomes cnt_val.
  - Count 0 never decrements, so there is no underflow wrap.
- Flags:
  - ovf and unf are sticky, cleared by err_clr or reset.
  - A set event in the same cycle as err_clr wins, so the flag stays 1.
- Stack is LIFO. The stack pointer is unchanged by every ns_sel other than CALL and RET.
- reset asserted mid-WAIT or mid-LOOP: immediate return to reset values; no partial state is retained.

Optional Feature:
- MICROSEQ_LOOP_EN defined: loop counter, cnt_load/cnt_val and ns_sel=7 LOOP behave as above.
- MICROSEQ_LOOP_EN undefined:
  - No counter register; loop_cnt is tied to 0 and cnt_load/cnt_val are ignored.
  - ns_sel=7 behaves as INC.

Decomposition:
- Package microseq_pkg holds:
  - ns_sel encodings NS_DECODE..NS_LOOP (3-bit localparams).
  - Condition index names COND_MOC=0, COND_ARM=1.
- Sub-module microseq_stack, parametrised on ADDR_W/STACK_DEPTH:
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, depth.
  - Same CLK/reset convention.
- Top level holds: address register, condition mux, next-address mux, loop counter, flags.

Test Plan:
1. Reset → uaddr=0, ovf=unf=0. Then INC at uaddr=255 (ADDR_W=8) → uaddr=0 (wrap).
2. WAIT with cond_sel=0, cond_in[0]=0 for 3 cycles, then 1 → uaddr held at 10 for 3 cycles, then 11. Repeat with cond_inv=1: advances while cond_in[0]=0.
3. CALL target=40 from uaddr=5, then RET at 40 → uaddr 40, then 6, stk_depth 1→0. Five nested CALLs with STACK_DEPTH=4 → ovf=1, depth=4. Four RETs return in LIFO order; a fifth RET → uaddr=0, unf=1.
4. cnt_load cnt_val=3, then LOOP target=20 repeatedly at uaddr=22 → branches 3 times (loop_cnt 2,1,0), 4th LOOP → 23. With the macro undefined: LOOP → 23 immediately, loop_cnt=0.
5. cnt_load=1 (val 7) concurrent with LOOP at loop_cnt=0 → uaddr=inc, loop_cnt=7. err_clr concurrent with an overflowing CALL → ovf stays 1.
6. DECODE with decode_addr=38 → uaddr=38. Drive reset low mid-LOOP → uaddr=0, loop_cnt=0 immediately, without waiting for CLK.
